alu_issue_ctrl: RTL and testbench

Initiator-side controller for the combinational ALU (opcodes 00 add, 01 multiply, 10 divide).
- Accepts one operation request over a valid/ready handshake and drives the ALU operand/opcode/carry-in ports.
- Holds those inputs stable for a programmable settle time, then captures the ALU result and flags.
- Returns result and flags over a second valid/ready handshake.
- Sits between the instruction sequencer and the ALU. Also keeps a sticky status register (N,Z,C,V) and a completed-operation counter.

---
 rtl/alu_issue_ctrl_if.sv | 52 +++++
 rtl/alu_issue_ctrl.sv | 129 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the sequencer-facing request/response channels and the ALU drive/return wires.
// valid/ready: a transfer happens on a rising edge where valid and ready are both 1; the
// sender holds its payload stable from asserting valid until that edge.
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 23
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH:0]   req_a;
    logic [WIDTH:0]   req_b;
    logic [1:0]       req_op;
    logic             req_ci;

    logic [WIDTH:0]   alu_a;
    logic [WIDTH:0]   alu_b;
    logic [1:0]       alu_op;
    logic             alu_ci;
    logic [WIDTH:0]   alu_out;
    logic             alu_co;
    logic             alu_neg;
    logic             alu_zero;
    logic             alu_carry;
    logic             alu_ovf;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH:0]   rsp_result;
    logic [3:0]       rsp_flags;
    logic             rsp_co;
    logic             rsp_err;

    logic [3:0]       status_nzcv;
    logic [15:0]      ops_done;

    modport master (
        output req_valid, req_a, req_b, req_op, req_ci, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_co, rsp_err,
               status_nzcv, ops_done
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_ci, rsp_ready,
               alu_out, alu_co, alu_neg, alu_zero, alu_carry, alu_ovf,
        output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_co, rsp_err,
               status_nzcv, ops_done, alu_a, alu_b, alu_op, alu_ci
    );

    modport alu (
        input  alu_a, alu_b, alu_op, alu_ci,
        output alu_out, alu_co, alu_neg, alu_zero, alu_carry, alu_ovf
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one operation at a time to a combinational ALU, holds its inputs for a settle
// window, captures result/flags and returns them; keeps sticky NZCV and a completion count.
module alu_issue_ctrl #(
    parameter int WIDTH  = 23,
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    alu_issue_ctrl_if.slave bus,
    output logic [1:0]      state_o
);
    localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
    localparam int CW         = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_EFF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic [WIDTH:0] alu_a_q;
    logic [WIDTH:0] alu_b_q;
    logic [1:0]     alu_op_q;
    logic           alu_ci_q;
    logic           req_ready_q;
    logic           rsp_valid_q;
    logic [WIDTH:0] rsp_result_q;
    logic [3:0]     rsp_flags_q;
    logic           rsp_co_q;
    logic           rsp_err_q;
    logic [3:0]     status_q;
    logic [15:0]    ops_done_q;
    logic [15:0]    ops_done_d;
    logic           req_legal;

    // Illegal opcode and divide-by-zero are rejected without touching the ALU.
    always_comb begin
        req_legal  = (bus.req_op != 2'b11) &&
                     !((bus.req_op == 2'b10) && (bus.req_b == '0));
        cnt_d      = cnt_q - 1'b1;
        ops_done_d = ops_done_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            alu_ci_q     <= 1'b0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_co_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            status_q     <= '0;
            ops_done_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_ready_q <= 1'b0;
                        if (req_legal) begin
                            alu_a_q  <= bus.req_a;
                            alu_b_q  <= bus.req_b;
                            alu_op_q <= bus.req_op;
                            alu_ci_q <= bus.req_ci;
                            cnt_q    <= CNT_LOAD;
                            state_q  <= DRIVE;
                        end else begin
                            rsp_result_q <= '0;
                            rsp_flags_q  <= '0;
                            rsp_co_q     <= 1'b0;
                            rsp_err_q    <= 1'b1;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= RESP;
                        end
                    end
                end
                DRIVE: begin
                    if (cnt_q == '0) begin
                        rsp_result_q <= bus.alu_out;
                        rsp_flags_q  <= {bus.alu_neg, bus.alu_zero, bus.alu_carry, bus.alu_ovf};
                        status_q     <= {bus.alu_neg, bus.alu_zero, bus.alu_carry, bus.alu_ovf};
                        rsp_co_q     <= bus.alu_co;
                        rsp_err_q    <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        ops_done_q  <= ops_done_d;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_ci      = alu_ci_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_flags   = rsp_flags_q;
    assign bus.rsp_co      = rsp_co_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.status_nzcv = status_q;
    assign bus.ops_done    = ops_done_q;
    assign state_o         = state_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU stub plus a transaction-level reference model.
module tb_alu_issue_ctrl;
    localparam int W = 23;
    localparam int S = 2;
    localparam int S_EFF = (S < 1) ? 1 : S;

    logic       clk;
    logic       rst;
    logic [1:0] state_o;
    int         compares;
    int         fails;

    alu_issue_ctrl_if #(.WIDTH(W)) bus ();

    alu_issue_ctrl #(.WIDTH(W), .SETTLE(S)) dut (
        .clk(clk), .rst(rst), .bus(bus), .state_o(state_o)
    );

    typedef struct packed {
        logic [W:0] out;
        logic       co, n, z, c, v;
    } alu_res_t;

    // Stand-in ALU: add / multiply / divide with its own flag rules.
    function automatic alu_res_t alu_model(input logic [W:0] a, input logic [W:0] b,
                                           input logic [1:0] op, input logic ci);
        alu_res_t r;
        logic [W+1:0]   s;
        logic [2*W+1:0] p;
        r = '0;
        case (op)
            2'b00: begin
                s = {1'b0, a} + {1'b0, b} + {{(W+1){1'b0}}, ci};
                r.out = s[W:0]; r.co = s[W+1]; r.c = s[W+1];
                r.v = (a[W] == b[W]) && (s[W] != a[W]);
            end
            2'b01: begin
                p = {{(W+1){1'b0}}, a} * {{(W+1){1'b0}}, b};
                r.out = p[W:0]; r.co = |p[2*W+1:W+1]; r.c = r.co; r.v = |p[2*W+1:W];
            end
            2'b10: begin
                if (b != '0) begin r.out = a / b; r.c = (a % b) != '0; end
                else r.out = '1;
            end
            default: r.out = a ^ b;
        endcase
        r.n = r.out[W];
        r.z = (r.out == '0);
        return r;
    endfunction

    alu_res_t alu_r;
    always_comb alu_r = alu_model(bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_ci);
    assign bus.alu_out   = alu_r.out;
    assign bus.alu_co    = alu_r.co;
    assign bus.alu_neg   = alu_r.n;
    assign bus.alu_zero  = alu_r.z;
    assign bus.alu_carry = alu_r.c;
    assign bus.alu_ovf   = alu_r.v;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: sticky flags of last legal op and completed-response count.
    logic [3:0]  status_m;
    logic [15:0] ops_m;
    logic [W:0]  exp_q[$];
    logic [5:0]  exp_meta_q[$];  // {err, co, flags}

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_req(input logic [W:0] a, input logic [W:0] b, input logic [1:0] op,
                            input logic ci, output bit to);
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        to = (n >= 20);
        bus.req_a = a; bus.req_b = b; bus.req_op = op; bus.req_ci = ci;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output bit to);
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        to = (bus.rsp_valid !== 1'b1);
    endtask

    task automatic finish_rsp(input int hold);
        repeat (hold) begin @(posedge clk); #1; end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compares++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset req_ready: got %b want 1", bus.req_ready); end
        compares++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset rsp_valid: got %b want 0", bus.rsp_valid); end
        compares++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_ci, bus.rsp_result, bus.rsp_flags, bus.rsp_co,
             bus.rsp_err, bus.status_nzcv, bus.ops_done} !== '0) begin
            fails++; $display("FAIL reset outputs: got a=%h b=%h res=%h st=%h ops=%h want all 0",
                              bus.alu_a, bus.alu_b, bus.rsp_result, bus.status_nzcv, bus.ops_done);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        status_m = '0; ops_m = '0;
    endtask

    task automatic test_add_basic;
        bit to; int lat;
        send_req(24'd5, 24'd5, 2'b00, 1'b0, to);
        compares++; if (bus.alu_a !== 24'd5) begin fails++; $display("FAIL add_basic alu_a: got %0d want 5", bus.alu_a); end
        wait_rsp(lat, to);
        compares++; if (to || lat != S_EFF + 1) begin fails++; $display("FAIL add_basic latency: got %0d want %0d", lat, S_EFF + 1); end
        compares++; if (bus.rsp_result !== 24'd10) begin fails++; $display("FAIL add_basic result: got %0d want 10", bus.rsp_result); end
        compares++; if ({bus.rsp_flags, bus.rsp_err} !== 5'b0) begin fails++; $display("FAIL add_basic flags/err: got %b/%b want 0000/0", bus.rsp_flags, bus.rsp_err); end
        status_m = 4'b0000;
        finish_rsp(0);
        ops_m++;
        compares++; if (bus.ops_done !== ops_m) begin fails++; $display("FAIL add_basic ops_done: got %0d want %0d", bus.ops_done, ops_m); end
    endtask

    task automatic test_add_carry;
        bit to; int lat;
        send_req(24'hFFFFFF, 24'd1, 2'b00, 1'b0, to);
        wait_rsp(lat, to);
        compares++; if (to || bus.rsp_result !== 24'd0) begin fails++; $display("FAIL add_carry result: got %h want 0", bus.rsp_result); end
        compares++; if (bus.rsp_flags !== 4'b0110 || bus.rsp_co !== 1'b1) begin fails++; $display("FAIL add_carry flags/co: got %b/%b want 0110/1", bus.rsp_flags, bus.rsp_co); end
        status_m = 4'b0110;
        compares++; if (bus.status_nzcv !== status_m) begin fails++; $display("FAIL add_carry status: got %b want %b", bus.status_nzcv, status_m); end
        finish_rsp(1);
        ops_m++;
    endtask

    task automatic test_reject;
        bit to; int lat;
        send_req(24'd13, 24'd0, 2'b10, 1'b0, to);
        wait_rsp(lat, to);
        compares++; if (to || lat != 1) begin fails++; $display("FAIL div0 latency: got %0d want 1", lat); end
        compares++; if ({bus.rsp_err, bus.rsp_result, bus.rsp_flags, bus.rsp_co} !== {1'b1, 29'b0}) begin
            fails++; $display("FAIL div0 response: got err=%b res=%h fl=%b co=%b want err=1 rest 0", bus.rsp_err, bus.rsp_result, bus.rsp_flags, bus.rsp_co); end
        compares++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== {24'hFFFFFF, 24'd1, 2'b00}) begin
            fails++; $display("FAIL div0 alu held: got a=%h b=%h op=%b want ffffff/1/00", bus.alu_a, bus.alu_b, bus.alu_op); end
        compares++; if (bus.status_nzcv !== status_m) begin fails++; $display("FAIL div0 status: got %b want %b", bus.status_nzcv, status_m); end
        finish_rsp(0);
        ops_m++;
        send_req(24'd7, 24'd9, 2'b11, 1'b1, to);
        wait_rsp(lat, to);
        compares++; if (to || bus.rsp_err !== 1'b1) begin fails++; $display("FAIL op11 err: got %b want 1", bus.rsp_err); end
        finish_rsp(0);
        ops_m++;
        compares++; if (bus.ops_done !== ops_m) begin fails++; $display("FAIL op11 ops_done: got %0d want %0d", bus.ops_done, ops_m); end
    endtask

    task automatic test_hold;
        bit to; int lat;
        send_req(24'd13, 24'd3, 2'b01, 1'b0, to);
        wait_rsp(lat, to);
        compares++; if (to || lat != S_EFF + 1) begin fails++; $display("FAIL hold latency: got %0d want %0d", lat, S_EFF + 1); end
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                bus.req_a = 24'd99; bus.req_b = 24'd1; bus.req_op = 2'b00; bus.req_valid = 1'b1;
            end
            compares++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 24'd39 || bus.req_ready !== 1'b0) begin
                fails++; $display("FAIL hold cycle %0d: got v=%b res=%0d rdy=%b want 1/39/0", i, bus.rsp_valid, bus.rsp_result, bus.req_ready);
            end
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        status_m = 4'b0000;
        finish_rsp(0);
        ops_m++;
        compares++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL hold after handshake: got rdy=%b v=%b want 1/0", bus.req_ready, bus.rsp_valid); end
        compares++; if (bus.alu_a !== 24'd13 || bus.status_nzcv !== status_m) begin fails++; $display("FAIL hold ignored req: got alu_a=%0d st=%b want 13/%b", bus.alu_a, bus.status_nzcv, status_m); end
    endtask

    task automatic test_reset_mid;
        bit to; int lat;
        send_req(24'd200, 24'd300, 2'b01, 1'b0, to);
        rst = 1'b1;
        #1;
        compares++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.rsp_valid, bus.ops_done, bus.status_nzcv} !== '0 || bus.req_ready !== 1'b1) begin
            fails++; $display("FAIL reset_mid outputs: got a=%h v=%b ops=%h rdy=%b want 0/0/0/1", bus.alu_a, bus.rsp_valid, bus.ops_done, bus.req_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        status_m = '0; ops_m = '0;
        for (int i = 0; i < 4; i++) begin
            compares++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_mid no rsp %0d: got %b want 0", i, bus.rsp_valid); end
            @(posedge clk); #1;
        end
        send_req(24'd1, 24'd2, 2'b00, 1'b0, to);
        wait_rsp(lat, to);
        compares++; if (to || bus.rsp_result !== 24'd3) begin fails++; $display("FAIL reset_mid result: got %0d want 3", bus.rsp_result); end
        finish_rsp(0);
        ops_m++;
        compares++; if (bus.ops_done !== ops_m) begin fails++; $display("FAIL reset_mid ops_done: got %0d want %0d", bus.ops_done, ops_m); end
    endtask

    task automatic test_random;
        bit to; int lat;
        logic [W:0] a, b, er; logic [1:0] op; logic ci; logic [5:0] em;
        bit legal; alu_res_t r;
        for (int i = 0; i < 150; i++) begin
            a = $urandom_range(0, 3) == 0 ? 24'hFFFFFF : W'($urandom);
            case ($urandom_range(0, 3))
                0: b = '0;
                1: b = $urandom_range(1, 15);
                default: b = W'($urandom);
            endcase
            op = $urandom_range(0, 3);
            ci = $urandom_range(0, 1);
            legal = !(op == 2'b11 || (op == 2'b10 && b == '0));
            r = alu_model(a, b, op, ci);
            if (legal) begin
                exp_q.push_back(r.out);
                exp_meta_q.push_back({1'b0, r.co, r.n, r.z, r.c, r.v});
            end else begin
                exp_q.push_back('0);
                exp_meta_q.push_back(6'b100000);
            end
            send_req(a, b, op, ci, to);
            wait_rsp(lat, to);
            er = exp_q.pop_front();
            em = exp_meta_q.pop_front();
            if (legal) status_m = em[3:0];
            compares++; if (to || lat != (legal ? S_EFF + 1 : 1)) begin fails++; $display("FAIL random %0d latency: got %0d want %0d", i, lat, legal ? S_EFF + 1 : 1); end
            compares++; if (bus.rsp_result !== er) begin fails++; $display("FAIL random %0d result: got %h want %h (op=%b)", i, bus.rsp_result, er, op); end
            compares++; if ({bus.rsp_err, bus.rsp_co, bus.rsp_flags} !== em) begin fails++; $display("FAIL random %0d err/co/flags: got %b want %b", i, {bus.rsp_err, bus.rsp_co, bus.rsp_flags}, em); end
            compares++; if (bus.status_nzcv !== status_m) begin fails++; $display("FAIL random %0d status: got %b want %b", i, bus.status_nzcv, status_m); end
            finish_rsp($urandom_range(0, 3));
            ops_m++;
            compares++; if (bus.ops_done !== ops_m) begin fails++; $display("FAIL random %0d ops_done: got %0d want %0d", i, bus.ops_done, ops_m); end
        end
    endtask

    task automatic test_wrap;
        bit to; int lat;
        force dut.ops_done_q = 16'hFFFD;
        #1;
        release dut.ops_done_q;
        ops_m = 16'hFFFD;
        for (int i = 0; i < 4; i++) begin
            send_req(W'($urandom), W'($urandom), (i == 3) ? 2'b00 : 2'b11, 1'b0, to);
            wait_rsp(lat, to);
            finish_rsp(0);
            ops_m++;
            compares++; if (to || bus.ops_done !== ops_m) begin fails++; $display("FAIL wrap step %0d ops_done: got %h want %h", i, bus.ops_done, ops_m); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        compares = 0; fails = 0;
        rst = 1'b0;
        bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0; bus.req_ci = 1'b0;
        bus.rsp_ready = 1'b0;
        #2;
        test_reset();
        test_add_basic();
        test_add_carry();
        test_reject();
        test_hold();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end
endmodule
